vptimer_port_arbiter: RTL
=========================

Name: vptimer_port_arbiter

Overview:
- Shares the single register port of the on-chip VP timer between two requesters: m0 (CPU bus adapter) and m1 (auxiliary sequencer, e.g. sound/tape engine that reprograms the timer).
- Serialises accesses, holds timer strobes until a ce-qualified edge, captures registered read data, and returns a one-cycle ack per transaction.
- Sits between the requesters and the timer's regwr/regrd/addr/data_i/data_o pins, in the same ce domain.

Parameters:
- ROUND_ROBIN, 1, 1 = alternate grant on contention; 0 = m0 fixed priority.
- M1_RD_CTRL_OK, 0, 0 = m1 read of control (offset 4'o12) is not issued to the timer, so it cannot clear readybit; rdata = 16'h0000. 1 = issued normally.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- ce  in  1  timer clock enable; the same signal drives the timer
- m0_req  in  1  request, held until m0_ack
- m0_we  in  1  1 = write, 0 = read
- m0_addr  in  4  timer register offset
- m0_wdata  in  16  write data
- m0_rdata  out  16  read data, valid while m0_ack = 1 and held afterwards
- m0_ack  out  1  one-cycle completion pulse
- m1_req, m1_we, m1_addr, m1_wdata, m1_rdata, m1_ack: same as m0
- t_regwr  out  1  to timer regwr
- t_regrd  out  1  to timer regrd
- t_addr  out  4  to timer addr
- t_data_i  out  16  to timer data_i
- t_data_o  in  16  from timer data_o (registered on the ce edge)
- busy  out  1  high in any state other than IDLE
- gnt  out  1  id of the current or last granted master

Behaviour:
- Reset (asynchronous): state IDLE; t_regwr = t_regrd = 0; t_addr = 0; t_data_i = 0; m*_ack = 0; m*_rdata = 0; busy = 0; gnt = 1, so m0 wins the first contention under ROUND_ROBIN.
- Reset mid-transaction aborts immediately. No ack is issued, and the timer is left with whatever writes already occurred.
- Valid offsets are 4'o06 (reload), 4'o10 (counter) and 4'o12 (control). Any other offset is "null": no strobe is issued, and a read returns 16'h0000.
- States are IDLE, ACCESS, RESP, ACK.
- IDLE:
  - Sample requests and choose a master.
  - Contention: ROUND_ROBIN = 1 grants the master opposite to gnt; ROUND_ROBIN = 0 grants m0.
  - On grant, latch we/addr/wdata into internal registers and update gnt.
  - Go to ACCESS, or to RESP if the access is null or a blocked m1 control read.
- ACCESS:
  - t_regwr = latched we; t_regrd = ~we; t_addr and t_data_i driven from the latched values. All outputs are registered and stable for the whole state.
  - Stay while ce = 0. On an edge with ce = 1 the timer performs the access; strobes drop and the next state is RESP.
- RESP: one cycle. t_data_o is now valid. On the edge, load the granted rdata with t_data_o (read), 0 (null or blocked read), or leave it unchanged (write). Next state is ACK.
- ACK:
  - Granted m*_ack = 1 for exactly this cycle; next state is IDLE. The other rdata and ack are untouched.
  - New requests are not sampled in ACK, so back-to-back accesses have a 1-cycle gap in IDLE.
- Latency with ce = 1 continuously: req sampled in cycle N gives strobe in N+1 and ack in N+3. Each extra ce = 0 cycle in ACCESS adds 1.
- A requester dropping req after grant does not abort the transaction; ack still pulses. A requester must not change we/addr/wdata while req is high; the values are latched at grant anyway.
- A request arriving during busy waits. There is no starvation under ROUND_ROBIN = 1.
- Only one strobe is ever active. t_regwr and t_regrd are never both high, and both are low outside ACCESS.

Test Plan:
- Reset, then m0 write 4'o06 = 16'h0123 with ce = 1: t_regwr high exactly 1 cycle with t_addr = 4'o06 and t_data_i = 16'h0123; m0_ack at req+3; timer reload reads back 16'h0123.
- m0 read 4'o10 while ce toggles 1-of-4: t_regrd held until a ce edge, then strobes drop; m0_rdata equals the timer counter captured on that edge; exactly one ack.
- m0 and m1 both request every cycle, ROUND_ROBIN = 1: grants alternate m0, m1, m0, m1, with no double acks. With ROUND_ROBIN = 0, m1 is granted only when m0 is idle.
- m1 read 4'o12 with readybit = 1 and M1_RD_CTRL_OK = 0: no t_regrd pulse, m1_rdata = 0, readybit still 1. A subsequent m0 read returns bit 7 set and clears readybit.
- m0 read 4'o03 (null): no strobe, m0_rdata = 16'h0000, ack at req+2.
- Assert reset_n low during ACCESS: strobes low in the same cycle, no ack. After release, busy = 0 and the next request completes normally.

Source files
------------

// File: rtl/vptimer_port_arbiter_if.sv
// Register-port bundle between one requester and the VP timer arbiter.
// The requester holds req until ack pulses; rdata stays valid after ack.
interface vptimer_port_arbiter_if;
  logic        req;
  logic        we;
  logic [3:0]  addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        ack;

  modport master (output req, we, addr, wdata, input rdata, ack);
  modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/vptimer_port_arbiter.sv
// Shares the VP timer register port between two requesters.
// Accesses are serialised, strobes wait for a ce-qualified edge, and each completes with a one-cycle ack.
module vptimer_port_arbiter #(
  parameter bit ROUND_ROBIN   = 1'b1,
  parameter bit M1_RD_CTRL_OK = 1'b0
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          ce_i,
  vptimer_port_arbiter_if.slave         m0,
  vptimer_port_arbiter_if.slave         m1,
  output logic                          t_regwr_o,
  output logic                          t_regrd_o,
  output logic [3:0]                    t_addr_o,
  output logic [15:0]                   t_datai_o,
  input  logic [15:0]                   t_datao_i,
  output logic                          busy_o,
  output logic                          gnt_o
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP, ACK} state_e;

  localparam logic [3:0] ADDR_RELOAD  = 4'o06;
  localparam logic [3:0] ADDR_COUNTER = 4'o10;
  localparam logic [3:0] ADDR_CTRL    = 4'o12;

  state_e      state_q, state_d;
  logic        gnt_q, gnt_d;
  logic        we_q, we_d;
  logic [3:0]  addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata0_q, rdata0_d;
  logic [15:0] rdata1_q, rdata1_d;
  logic        regwr_q, regwr_d;
  logic        regrd_q, regrd_d;
  logic        ack0_q, ack0_d;
  logic        ack1_q, ack1_d;
  logic        pick;
  logic        skipNew;
  logic        skipLatched;
  logic [15:0] respData;

  // A "skipped" access never reaches the timer: unknown offset, or an m1 read of control when that is blocked.
  function automatic logic isSkipped(input logic master, input logic we, input logic [3:0] addr);
    logic valid;
    valid = (addr == ADDR_RELOAD) || (addr == ADDR_COUNTER) || (addr == ADDR_CTRL);
    return !valid || (master && !we && (addr == ADDR_CTRL) && !M1_RD_CTRL_OK);
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      gnt_q    <= 1'b1;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      regwr_q  <= 1'b0;
      regrd_q  <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      regwr_q  <= regwr_d;
      regrd_q  <= regrd_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
    end
  end

  // Under round robin gnt_q remembers the last winner, so contention goes to the other master.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    pick    = 1'b0;
    skipNew = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (m0.req || m1.req) begin
          if (m0.req && m1.req) pick = ROUND_ROBIN ? ~gnt_q : 1'b0;
          else                  pick = m1.req;
          gnt_d   = pick;
          we_d    = pick ? m1.we    : m0.we;
          addr_d  = pick ? m1.addr  : m0.addr;
          wdata_d = pick ? m1.wdata : m0.wdata;
          skipNew = isSkipped(pick, we_d, addr_d);
          state_d = skipNew ? RESP : ACCESS;
        end
      end
      ACCESS:  if (ce_i) state_d = RESP;
      RESP:    state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    skipLatched = isSkipped(gnt_q, we_q, addr_q);
    respData    = skipLatched ? 16'h0000 : t_datao_i;
    regwr_d     = (state_d == ACCESS) && we_d;
    regrd_d     = (state_d == ACCESS) && !we_d;
    ack0_d      = (state_d == ACK) && !gnt_q;
    ack1_d      = (state_d == ACK) && gnt_q;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    if (state_q == RESP && !we_q) begin
      if (gnt_q) rdata1_d = respData;
      else       rdata0_d = respData;
    end
  end

  assign t_regwr_o = regwr_q;
  assign t_regrd_o = regrd_q;
  assign t_addr_o  = addr_q;
  assign t_datai_o = wdata_q;
  assign busy_o    = (state_q != IDLE);
  assign gnt_o     = gnt_q;
  assign m0.rdata  = rdata0_q;
  assign m0.ack    = ack0_q;
  assign m1.rdata  = rdata1_q;
  assign m1.ack    = ack1_q;

endmodule
